hazard_unit: RTL and testbench

- Hazard and stall controller for the 5-stage RISC-V pipeline (F/D/E/M/W) driven by control_unit.
- Generates forwarding selects, stall/flush controls for the pipeline registers, and freezes the whole pipeline while data memory is busy.
- Sequential content: post-reset flush sequencer, memory-wait FSM with timeout, saturating stall/flush performance counters.

---
 rtl/hazard_unit_if.sv | 50 +++++
 rtl/hazard_unit.sv | 166 ++++++++++++++++
 tb/tb_hazard_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Purpose : bundles the pipeline-side signals of the hazard unit (register indices, write enables, memory handshake, control outputs).
// Latency : none; this is a wiring bundle only.
// Backpressure: MemReqM/MemReadyM carry the data-memory handshake that the hazard unit turns into a pipeline freeze.
// Ports   : master = pipeline/datapath side (drives indices and status), slave = hazard unit (drives forward/stall/flush/counters).
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    // Register indices seen in each stage
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    // Stage status
    logic             RegWriteM;
    logic             RegWriteW;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    // Controls back to the pipeline
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemTimeout, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Purpose : hazard/stall controller for the F/D/E/M/W pipeline: forwarding selects, load-use and branch stall/flush, memory-wait freeze.
// Latency : stall/flush/forward outputs are combinational (Mealy) in the same cycle; MemTimeout and counters are registered (visible next cycle).
// Backpressure: MemReqM && !MemReadyM freezes F/D/E/M and bubbles W until ready, or until MEM_TIMEOUT cycles force a release.
// Ports   : clk, rst (synchronous, active-high) plus hif (slave modport of hazard_unit_if) carrying all pipeline signals.
module hazard_unit #(
    parameter int RESET_FLUSH_CYCLES = 3,
    parameter int MEM_TIMEOUT        = 16,  // must be >= 2
    parameter int CNT_W              = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hif
);

    localparam int RF_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [RF_W-1:0]   RF_LAST   = RF_W'(RESET_FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RF_W-1:0]   rf_cnt_q, rf_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic       lw_stall;
    logic       mem_pending;
    logic       timeout_fire;
    logic       mem_stall;

    // M-stage result is younger than W-stage, so it wins; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign lw_stall = hif.ResultSrcE0 && (hif.RdE != 5'd0) &&
                      ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));

    assign mem_pending  = hif.MemReqM && !hif.MemReadyM;
    // On the last allowed wait cycle the freeze is dropped even though memory has not answered.
    assign timeout_fire = (state_q == MEM_WAIT) && mem_pending && (wait_cnt_q == WAIT_LAST);
    assign mem_stall    = mem_pending && !timeout_fire;

    always_comb begin
        state_d     = state_q;
        rf_cnt_d    = rf_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;

        if (rst || (state_q == RST_FLUSH)) begin
            // Hold fetch and keep D/E empty while the pipeline comes out of reset.
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (rf_cnt_q == RF_LAST) begin
                state_d  = RUN;
                rf_cnt_d = '0;
            end else begin
                rf_cnt_d = rf_cnt_q + 1'b1;
            end
        end else begin
            fwd_a = fwd_sel(hif.Rs1E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);
            fwd_b = fwd_sel(hif.Rs2E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);

            if (mem_stall) begin
                // Full freeze; a pending branch flush is suppressed because the
                // branch stays in E and re-asserts PCSrcE once released.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
                state_d = MEM_WAIT;
                if (state_q == MEM_WAIT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_d = WAIT_W'(1);
                end
            end else begin
                stall_f    = lw_stall;
                stall_d    = lw_stall;
                flush_d    = hif.PCSrcE;
                flush_e    = lw_stall | hif.PCSrcE;
                state_d    = RUN;
                wait_cnt_d = '0;
                if (timeout_fire) begin
                    timeout_d = 1'b1;
                end
            end

            if ((stall_f || stall_d || stall_e || stall_m) && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            // Outside reset flush, FlushD can only come from a taken branch.
            if (flush_d && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_FLUSH;
            rf_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rf_cnt_q    <= rf_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.ForwardAE  = fwd_a;
    assign hif.ForwardBE  = fwd_b;
    assign hif.StallF     = stall_f;
    assign hif.StallD     = stall_d;
    assign hif.StallE     = stall_e;
    assign hif.StallM     = stall_m;
    assign hif.FlushD     = flush_d;
    assign hif.FlushE     = flush_e;
    assign hif.FlushW     = flush_w;
    assign hif.MemTimeout = timeout_q;
    assign hif.StallCount = stall_cnt_q;
    assign hif.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Purpose : directed scoreboard bench for hazard_unit; driver queues expected outputs, monitor compares on the falling edge.
// Latency : control outputs checked in the cycle the inputs are applied; counters/MemTimeout checked one cycle after the event.
// Backpressure: memory-wait and timeout sequences are driven explicitly via MemReqM/MemReadyM.
module tb_hazard_unit;

    localparam int CNT_W = 4;  // narrow counters so saturation is reachable

    // ctl layout: {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [10:0] C_IDLE = 11'b00_00_0000_000;
    localparam logic [10:0] C_RST  = 11'b00_00_1000_110;
    localparam logic [10:0] C_FRZ  = 11'b00_00_1111_001;
    localparam logic [10:0] C_LW   = 11'b00_00_1100_010;
    localparam logic [10:0] C_BR   = 11'b00_00_0000_110;
    localparam logic [10:0] C_BRLW = 11'b00_00_1100_110;
    localparam logic [10:0] F_A10  = 11'b10_00_0000_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_unit #(
        .RESET_FLUSH_CYCLES(3),
        .MEM_TIMEOUT       (16),
        .CNT_W             (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

    typedef struct {
        string            name;
        logic [10:0]      ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             to;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [CNT_W-1:0] exp_sc = '0;
    logic [CNT_W-1:0] exp_fc = '0;
    logic             exp_to = 1'b0;

    task automatic clr();
        hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
        hif.RdE = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.ResultSrcE0 = 1'b0;
        hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
    endtask

    // Queue the expectation for the current cycle, then advance one clock and
    // apply the hand-specified counter/timeout effects of this cycle.
    task automatic step(input string name, input logic [10:0] ctl,
                        input bit sinc, input bit finc, input bit to_set);
        exp_t e;
        e.name = name; e.ctl = ctl; e.sc = exp_sc; e.fc = exp_fc; e.to = exp_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_sc = '0; exp_fc = '0; exp_to = 1'b0;
        end else begin
            if (sinc && (exp_sc != '1)) exp_sc = exp_sc + 1'b1;
            if (finc && (exp_fc != '1)) exp_fc = exp_fc + 1'b1;
            if (to_set) exp_to = 1'b1;
        end
    endtask

    // Monitor: outputs are always presented; compare whenever an expectation is queued.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [10:0] act;
            e   = sb.pop_front();
            act = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
                   hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};
            vectors++;
            if (act !== e.ctl || hif.StallCount !== e.sc || hif.FlushCount !== e.fc ||
                hif.MemTimeout !== e.to) begin
                miscompares++;
                $display("FAIL %s @%0t: got ctl=%b sc=%0d fc=%0d to=%b, expected ctl=%b sc=%0d fc=%0d to=%b",
                         e.name, $time, act, hif.StallCount, hif.FlushCount, hif.MemTimeout,
                         e.ctl, e.sc, e.fc, e.to);
            end
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset and post-reset flush window
        step("rst_hold", C_RST, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_flush", C_RST, 0, 0, 0);
        step("idle", C_IDLE, 0, 0, 0);

        // Forwarding priority and x0
        hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.RdW = 5'd5; hif.RegWriteW = 1'b1; hif.Rs1E = 5'd5;
        step("fwd_m", {2'b10, 2'b00, 7'b0}, 0, 0, 0);
        hif.RegWriteM = 1'b0; hif.Rs2E = 5'd5;
        step("fwd_w", {2'b01, 2'b01, 7'b0}, 0, 0, 0);
        hif.RegWriteM = 1'b1; hif.Rs1E = 5'd0; hif.RdM = 5'd0; hif.Rs2E = 5'd0;
        step("fwd_x0", C_IDLE, 0, 0, 0);
        hif.RdM = 5'd6; hif.Rs1E = 5'd5; hif.Rs2E = 5'd6;
        step("fwd_mix", {2'b01, 2'b10, 7'b0}, 0, 0, 0);
        clr();

        // Load-use, x0, branch
        hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        step("lw_use", C_LW, 1, 0, 0);
        hif.RdE = 5'd0; hif.Rs2D = 5'd0;
        step("lw_x0", C_IDLE, 0, 0, 0);
        hif.RdE = 5'd7; hif.Rs1D = 5'd7; hif.PCSrcE = 1'b1;
        step("br_lw", C_BRLW, 1, 1, 0);
        hif.ResultSrcE0 = 1'b0;
        step("br", C_BR, 0, 1, 0);
        clr();

        // Memory wait with a pending branch and M-stage forwarding
        hif.MemReqM = 1'b1; hif.PCSrcE = 1'b1; hif.RdM = 5'd3; hif.RegWriteM = 1'b1; hif.Rs1E = 5'd3;
        for (int i = 0; i < 4; i++) step("mem_wait", C_FRZ | F_A10, 1, 0, 0);
        hif.MemReadyM = 1'b1;
        step("mem_release", C_BR | F_A10, 0, 1, 0);
        clr();
        step("idle_after_wait", C_IDLE, 0, 0, 0);

        // Reset on the cycle the timeout would fire: no timeout recorded
        hif.MemReqM = 1'b1;
        for (int i = 0; i < 15; i++) step("abort_wait", C_FRZ, 1, 0, 0);
        rst = 1'b1;
        step("rst_abort", C_RST, 0, 0, 0);
        rst = 1'b0;
        clr();
        for (int i = 0; i < 3; i++) step("abort_flush", C_RST, 0, 0, 0);
        step("abort_idle", C_IDLE, 0, 0, 0);

        // Timeout: 15 frozen cycles, forced release on the 16th
        hif.MemReqM = 1'b1;
        for (int i = 0; i < 15; i++) step("to_wait", C_FRZ, 1, 0, 0);
        step("to_fire", C_IDLE, 0, 0, 1);
        hif.MemReqM = 1'b0;
        step("to_sticky", C_IDLE, 0, 0, 0);
        step("to_sticky2", C_IDLE, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
